// File: rtl/complete_arbiter.sv
// Completion/writeback arbiter: one holding slot per functional unit, up to CDB_W
// held results granted per cycle in round-robin order onto registered CDB lanes.

// One holding register per functional unit.
module complete_arbiter_slot #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         squash,
  input  logic         fu_valid,
  input  logic         grant,
  input  logic [W-1:0] fu_data,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);
  // A slot frees up in the same cycle its held result is granted, so an FU can
  // stream one result per cycle through it. Nothing is accepted while squashing.
  assign ready = ~squash & (~valid | grant);

  // Squash wipes the slot; a new load wins over the grant-clear (back-to-back).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (squash) begin
      valid <= 1'b0;
    end else if (fu_valid && ready) begin
      valid <= 1'b1;
      data  <= fu_data;
    end else if (grant) begin
      valid <= 1'b0;
    end
  end
endmodule

// One registered writeback lane; every field reads zero when the lane is idle.
module complete_arbiter_lane #(
  parameter int XLEN  = 32,
  parameter int PR_W  = 6,
  parameter int ROB_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash,
  input  logic             granted,
  input  logic [PR_W-1:0]  grant_pr,
  input  logic [XLEN-1:0]  grant_value,
  input  logic [ROB_W-1:0] grant_rob,
  input  logic             grant_br,
  input  logic [XLEN-1:0]  grant_tpc,
  output logic             valid,
  output logic [PR_W-1:0]  pr,
  output logic [XLEN-1:0]  value,
  output logic [ROB_W-1:0] rob,
  output logic             br,
  output logic [XLEN-1:0]  tpc
);
  // Reloaded every cycle; the redirect PC is only exposed for taken branches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      pr    <= '0;
      value <= '0;
      rob   <= '0;
      br    <= 1'b0;
      tpc   <= '0;
    end else if (squash || !granted) begin
      valid <= 1'b0;
      pr    <= '0;
      value <= '0;
      rob   <= '0;
      br    <= 1'b0;
      tpc   <= '0;
    end else begin
      valid <= 1'b1;
      pr    <= grant_pr;
      value <= grant_value;
      rob   <= grant_rob;
      br    <= grant_br;
      tpc   <= grant_br ? grant_tpc : '0;
    end
  end
endmodule

module complete_arbiter #(
  parameter int NUM_FU = 8,
  parameter int CDB_W  = 3,
  parameter int XLEN   = 32,
  parameter int PR_W   = 6,
  parameter int ROB_W  = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic [NUM_FU-1:0]         fu_valid,
  input  logic [NUM_FU*PR_W-1:0]    fu_dest_pr,
  input  logic [NUM_FU*XLEN-1:0]    fu_value,
  input  logic [NUM_FU*ROB_W-1:0]   fu_rob_entry,
  input  logic [NUM_FU-1:0]         fu_take_branch,
  input  logic [NUM_FU*XLEN-1:0]    fu_target_pc,
  output logic [NUM_FU-1:0]         fu_ready,
  output logic [CDB_W-1:0]          cdb_valid,
  output logic [CDB_W*PR_W-1:0]     cdb_pr,
  output logic [CDB_W*XLEN-1:0]     cdb_value,
  output logic [CDB_W*ROB_W-1:0]    complete_entry,
  output logic [CDB_W-1:0]          precise_state_valid,
  output logic [CDB_W*XLEN-1:0]     target_pc,
  output logic [31:0]               stall_cycles
);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [PR_W-1:0]  pr;
    logic [XLEN-1:0]  value;
    logic [ROB_W-1:0] rob;
    logic             br;
    logic [XLEN-1:0]  tpc;
  } entry_t;

  localparam int ENT_W = $bits(entry_t);

  logic [NUM_FU-1:0]             hold_valid;
  logic [NUM_FU-1:0]             grant;
  entry_t                        fu_ent   [NUM_FU];
  entry_t                        hold_ent [NUM_FU];
  logic [NUM_FU-1:0][CDB_W-1:0]  lane_hot;   // [fu][lane]: fu is granted onto lane
  logic [CDB_W-1:0]              lane_use;
  entry_t                        lane_ent [CDB_W];
  logic [PTR_W-1:0]              rr_ptr;
  logic [PTR_W-1:0]              rr_nxt;
  logic                          any_grant;
  logic                          over_sub;

  // Per-FU holding slots.
  for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
    assign fu_ent[i] = '{
      pr:    fu_dest_pr[i*PR_W +: PR_W],
      value: fu_value[i*XLEN +: XLEN],
      rob:   fu_rob_entry[i*ROB_W +: ROB_W],
      br:    fu_take_branch[i],
      tpc:   fu_target_pc[i*XLEN +: XLEN]
    };

    complete_arbiter_slot #(.W(ENT_W)) u_slot (
      .clock    (clock),
      .reset    (reset),
      .squash   (squash),
      .fu_valid (fu_valid[i]),
      .grant    (grant[i]),
      .fu_data  (fu_ent[i]),
      .ready    (fu_ready[i]),
      .valid    (hold_valid[i]),
      .data     (hold_ent[i])
    );
  end

  // Circular scan from rr_ptr; the j-th valid slot found goes to lane j, and the
  // pointer moves one past the last grant so leftovers lead next cycle.
  always_comb begin
    int               slot;
    int               cnt;
    logic [PTR_W-1:0] idx;
    grant    = '0;
    lane_hot = '0;
    rr_nxt   = rr_ptr;
    cnt      = 0;
    slot     = 0;
    idx      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      slot = int'(rr_ptr) + k;
      if (slot >= NUM_FU) slot = slot - NUM_FU;
      idx = PTR_W'(slot);
      if (hold_valid[idx] && (cnt < CDB_W)) begin
        grant[idx] = 1'b1;
        for (int j = 0; j < CDB_W; j++) begin
          if (cnt == j) lane_hot[idx][j] = 1'b1;
        end
        if (slot + 1 >= NUM_FU) rr_nxt = '0;
        else                    rr_nxt = PTR_W'(slot + 1);
        cnt = cnt + 1;
      end
    end
  end

  assign any_grant = |grant;
  assign over_sub  = $countones(hold_valid) > CDB_W;

  // Gather each lane's winning slot; at most one slot is hot per lane.
  always_comb begin
    lane_use = '0;
    for (int j = 0; j < CDB_W; j++) begin
      lane_ent[j] = '0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (lane_hot[i][j]) begin
          lane_use[j] = 1'b1;
          lane_ent[j] = hold_ent[i];
        end
      end
    end
  end

  // Registered writeback lanes.
  for (genvar j = 0; j < CDB_W; j++) begin : g_lane
    complete_arbiter_lane #(.XLEN(XLEN), .PR_W(PR_W), .ROB_W(ROB_W)) u_lane (
      .clock       (clock),
      .reset       (reset),
      .squash      (squash),
      .granted     (lane_use[j]),
      .grant_pr    (lane_ent[j].pr),
      .grant_value (lane_ent[j].value),
      .grant_rob   (lane_ent[j].rob),
      .grant_br    (lane_ent[j].br),
      .grant_tpc   (lane_ent[j].tpc),
      .valid       (cdb_valid[j]),
      .pr          (cdb_pr[j*PR_W +: PR_W]),
      .value       (cdb_value[j*XLEN +: XLEN]),
      .rob         (complete_entry[j*ROB_W +: ROB_W]),
      .br          (precise_state_valid[j]),
      .tpc         (target_pc[j*XLEN +: XLEN])
    );
  end

  // Round-robin pointer and stall counter survive a squash untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr       <= '0;
      stall_cycles <= '0;
    end else if (!squash) begin
      if (any_grant) rr_ptr <= rr_nxt;
      if (over_sub)  stall_cycles <= stall_cycles + 32'd1;
    end
  end
endmodule

// File: tb/tb_complete_arbiter.sv
// Scoreboard bench for complete_arbiter: a behavioural model predicts each cycle's
// lane outputs, which are queued at drive time and compared after the clock edge.
module tb_complete_arbiter;
  localparam int NUM_FU = 8;
  localparam int CDB_W  = 3;
  localparam int XLEN   = 32;
  localparam int PR_W   = 6;
  localparam int ROB_W  = 5;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    squash;
  logic [NUM_FU-1:0]       fu_valid;
  logic [NUM_FU*PR_W-1:0]  fu_dest_pr;
  logic [NUM_FU*XLEN-1:0]  fu_value;
  logic [NUM_FU*ROB_W-1:0] fu_rob_entry;
  logic [NUM_FU-1:0]       fu_take_branch;
  logic [NUM_FU*XLEN-1:0]  fu_target_pc;
  logic [NUM_FU-1:0]       fu_ready;
  logic [CDB_W-1:0]        cdb_valid;
  logic [CDB_W*PR_W-1:0]   cdb_pr;
  logic [CDB_W*XLEN-1:0]   cdb_value;
  logic [CDB_W*ROB_W-1:0]  complete_entry;
  logic [CDB_W-1:0]        precise_state_valid;
  logic [CDB_W*XLEN-1:0]   target_pc;
  logic [31:0]             stall_cycles;

  complete_arbiter #(.NUM_FU(NUM_FU), .CDB_W(CDB_W), .XLEN(XLEN), .PR_W(PR_W), .ROB_W(ROB_W)) dut (
    .clock(clock), .reset(reset), .squash(squash), .fu_valid(fu_valid),
    .fu_dest_pr(fu_dest_pr), .fu_value(fu_value), .fu_rob_entry(fu_rob_entry),
    .fu_take_branch(fu_take_branch), .fu_target_pc(fu_target_pc), .fu_ready(fu_ready),
    .cdb_valid(cdb_valid), .cdb_pr(cdb_pr), .cdb_value(cdb_value),
    .complete_entry(complete_entry), .precise_state_valid(precise_state_valid),
    .target_pc(target_pc), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [PR_W-1:0]  pr;
    logic [XLEN-1:0]  value;
    logic [ROB_W-1:0] rob;
    logic             br;
    logic [XLEN-1:0]  tpc;
  } ent_t;

  typedef struct {
    logic [CDB_W-1:0]       v;
    logic [CDB_W*PR_W-1:0]  pr;
    logic [CDB_W*XLEN-1:0]  value;
    logic [CDB_W*ROB_W-1:0] rob;
    logic [CDB_W-1:0]       psv;
    logic [CDB_W*XLEN-1:0]  tpc;
    logic [31:0]            stall;
  } out_t;

  out_t              sb[$];
  logic [NUM_FU-1:0] in_v;
  ent_t              in_e [NUM_FU];
  logic [NUM_FU-1:0] m_hv;
  ent_t              m_he [NUM_FU];
  int                m_rr;
  logic [31:0]       m_stall;
  int                errors = 0;
  int                checks = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_fu(input int i, input int pr, input logic [XLEN-1:0] val, input int rob,
                        input logic br, input logic [XLEN-1:0] tpc);
    in_v[i]       = 1'b1;
    in_e[i].pr    = PR_W'(pr);
    in_e[i].value = val;
    in_e[i].rob   = ROB_W'(rob);
    in_e[i].br    = br;
    in_e[i].tpc   = tpc;
  endtask

  task automatic drive();
    fu_valid = in_v;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_dest_pr[i*PR_W +: PR_W]     = in_e[i].pr;
      fu_value[i*XLEN +: XLEN]       = in_e[i].value;
      fu_rob_entry[i*ROB_W +: ROB_W] = in_e[i].rob;
      fu_take_branch[i]              = in_e[i].br;
      fu_target_pc[i*XLEN +: XLEN]   = in_e[i].tpc;
    end
  endtask

  // One clock: drive, predict, then compare the registered outputs after the edge.
  task automatic step();
    logic [NUM_FU-1:0] g;
    logic [NUM_FU-1:0] rdy;
    out_t o;
    out_t e;
    int   lane;
    int   last;
    int   i;
    drive();
    @(negedge clock);
    g = '0; lane = 0; last = 0;
    o.v = '0; o.pr = '0; o.value = '0; o.rob = '0; o.psv = '0; o.tpc = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      i = (m_rr + k) % NUM_FU;
      if (m_hv[i] && lane < CDB_W) begin
        g[i] = 1'b1;
        o.v[lane]                     = 1'b1;
        o.pr[lane*PR_W +: PR_W]       = m_he[i].pr;
        o.value[lane*XLEN +: XLEN]    = m_he[i].value;
        o.rob[lane*ROB_W +: ROB_W]    = m_he[i].rob;
        o.psv[lane]                   = m_he[i].br;
        o.tpc[lane*XLEN +: XLEN]      = m_he[i].br ? m_he[i].tpc : '0;
        lane++;
        last = i;
      end
    end
    rdy = squash ? '0 : (~m_hv | g);
    chk("fu_ready", fu_ready, rdy);
    if (squash) begin
      o.v = '0; o.pr = '0; o.value = '0; o.rob = '0; o.psv = '0; o.tpc = '0;
    end else begin
      if ($countones(m_hv) > CDB_W) m_stall = m_stall + 32'd1;
      if (lane > 0) m_rr = (last + 1) % NUM_FU;
    end
    o.stall = m_stall;
    for (int f = 0; f < NUM_FU; f++) begin
      if (squash) m_hv[f] = 1'b0;
      else if (in_v[f] && rdy[f]) begin
        m_hv[f] = 1'b1;
        m_he[f] = in_e[f];
      end else if (g[f]) m_hv[f] = 1'b0;
    end
    sb.push_back(o);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("cdb_valid", cdb_valid, e.v);
    chk("cdb_pr", cdb_pr, e.pr);
    chk("cdb_value", cdb_value, e.value);
    chk("complete_entry", complete_entry, e.rob);
    chk("precise_state_valid", precise_state_valid, e.psv);
    chk("target_pc", target_pc, e.tpc);
    chk("stall_cycles", stall_cycles, e.stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    m_hv = '0; m_rr = 0; m_stall = '0;
    squash = 1'b0;
    in_v = '0;
    for (int i = 0; i < NUM_FU; i++) set_fu(i, i + 1, XLEN'(32'hF00 + i), i, 1'b1, XLEN'(32'h500 + i));
    reset = 1'b1;
    drive();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cdb_valid", cdb_valid, 3'b000);
    chk("rst_cdb_pr", cdb_pr, 0);
    chk("rst_psv", precise_state_valid, 3'b000);
    chk("rst_stall", stall_cycles, 0);
    reset = 1'b0;
    #1;
    chk("rst_ready", fu_ready, 8'hFF);
    in_v = '0;
    step(); step();

    // single result on FU2
    set_fu(2, 5, 32'hDEAD, 3, 1'b0, 32'h0);
    step();
    in_v = '0;
    step();
    chk("fu2_valid", cdb_valid, 3'b001);
    chk("fu2_pr", cdb_pr[PR_W-1:0], 6'd5);
    chk("fu2_rob", complete_entry[ROB_W-1:0], 5'd3);
    chk("fu2_value", cdb_value[XLEN-1:0], 32'hDEAD);

    // FU7 alone brings the pointer back to 0
    set_fu(7, 9, 32'h1234, 7, 1'b0, 32'h0);
    step();
    in_v = '0;
    step(); step();

    // all eight FUs at once
    for (int i = 0; i < NUM_FU; i++) set_fu(i, i + 1, XLEN'(32'h100 + i), i, 1'b0, 32'h0);
    step();
    in_v = '0;
    step();
    chk("all8_c1_valid", cdb_valid, 3'b111);
    chk("all8_c1_pr", cdb_pr, {6'd3, 6'd2, 6'd1});
    step();
    chk("all8_c2_valid", cdb_valid, 3'b111);
    chk("all8_c2_pr", cdb_pr, {6'd6, 6'd5, 6'd4});
    step();
    chk("all8_c3_valid", cdb_valid, 3'b011);
    chk("all8_c3_pr", cdb_pr, {6'd0, 6'd8, 6'd7});
    chk("all8_stall", stall_cycles, 32'd2);
    step();

    // FU5 back-to-back
    set_fu(5, 11, 32'hAAAA, 4, 1'b0, 32'h0);
    step();
    in_v = '0;
    set_fu(5, 12, 32'hBBBB, 5, 1'b0, 32'h0);
    drive();
    #1;
    chk("b2b_ready5", fu_ready[5], 1'b1);
    step();
    chk("b2b_first", cdb_value[XLEN-1:0], 32'hAAAA);
    in_v = '0;
    step();
    chk("b2b_second", cdb_value[XLEN-1:0], 32'hBBBB);
    chk("b2b_second_pr", cdb_pr[PR_W-1:0], 6'd12);

    // taken branch on FU1 alongside a plain result on FU3
    set_fu(1, 13, 32'h55, 6, 1'b1, 32'h0000_1040);
    set_fu(3, 14, 32'h66, 7, 1'b0, 32'hFFFF_0000);
    step();
    in_v = '0;
    step();
    chk("br_valid", cdb_valid, 3'b011);
    chk("br_psv", precise_state_valid, 3'b001);
    chk("br_tpc0", target_pc[XLEN-1:0], 32'h0000_1040);
    chk("br_tpc_rest", target_pc[CDB_W*XLEN-1:XLEN], 64'h0);

    // squash with four entries held
    for (int i = 0; i < 7; i++) set_fu(i, 20 + i, XLEN'(32'h200 + i), 8 + i, (i == 0), XLEN'(32'h3000 + i));
    step();
    in_v = '0;
    step();
    chk("sq_pre_valid", cdb_valid, 3'b111);
    squash = 1'b1;
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 40 + i, XLEN'(32'h400 + i), i, 1'b1, 32'h1);
    drive();
    #1;
    chk("sq_ready", fu_ready, 8'h00);
    step();
    chk("sq_valid", cdb_valid, 3'b000);
    chk("sq_psv", precise_state_valid, 3'b000);
    squash = 1'b0;
    in_v = '0;
    step();
    chk("sq_dropped", cdb_valid, 3'b000);
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 30 + i, XLEN'(32'h600 + i), i, 1'b0, 32'h0);
    step();
    in_v = '0;
    step();
    chk("sq_rr_kept", cdb_pr, {6'd31, 6'd30, 6'd37});
    repeat (3) step();

    // random traffic with occasional squashes
    for (int c = 0; c < 300; c++) begin
      in_v = NUM_FU'($urandom);
      for (int i = 0; i < NUM_FU; i++) begin
        in_e[i].pr    = PR_W'($urandom);
        in_e[i].value = $urandom;
        in_e[i].rob   = ROB_W'($urandom);
        in_e[i].br    = 1'($urandom);
        in_e[i].tpc   = $urandom;
      end
      squash = ($urandom_range(0, 11) == 0);
      step();
    end
    squash = 1'b0;
    in_v = '0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
